mips_step_ctrl: RTL and testbench
=================================

Name: mips_step_ctrl

Overview:
- Sequences execution of the MIPS `system` core on the FPGA board.
- Generates a one-cycle clock-enable `cpu_ce` for the core from three sources:
  - single-step on a debounced button edge;
  - free-run at a divided tick rate;
  - halt when the fetched PC matches a breakpoint address.
- Sits between `button_debouncer`/`clk_gen` and `system`, in the 100 MHz domain, and replaces direct clocking of the core from the button.
- Counts the steps it issues, for display on the 7-segment mux.

Parameters:
- RUN_DIV, 5000, number of `tick` pulses between consecutive steps in RUN (must be ≥1).
- CNT_W, 32, width of `step_cnt`.

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle enable pulse from `clk_gen` (5 kHz).
- btn  in  1  debounced button level, synchronous to `clk`.
- run_sw  in  1  1 = free-run requested, 0 = single-step mode.
- bp_en  in  1  enables breakpoint compare.
- bp_addr  in  32  breakpoint PC.
- pc_current  in  32  current PC from core.
- clr_cnt  in  1  synchronous clear of `step_cnt`.
- cpu_ce  out  1  one-cycle step enable to core.
- halted  out  1  high while in HALT.
- state  out  2  current FSM state encoding.
- step_cnt  out  CNT_W  number of `cpu_ce` pulses issued (wraps).

Behaviour:
- Reset (async, active-high, any time including mid-run):
  - state=IDLE; `cpu_ce`=0; `halted`=0; `step_cnt`=0; `btn_q`=0; `div_cnt`=0.
- Edge detect: `btn_rise = btn & ~btn_q`; `btn_q` is registered every cycle.
- All outputs are registered. `cpu_ce` is never high for two consecutive cycles.
- States: IDLE=2'd0, RUN=2'd1, HALT=2'd2 (2'd3 is reserved).
- IDLE:
  - `btn_rise` at cycle N → `cpu_ce`=1 in cycle N+1; stay in IDLE.
  - `run_sw`=1 → RUN next cycle, with `div_cnt`=0.
  - If `run_sw`=1 and `btn_rise` occur together, RUN wins and no step is issued.
- RUN:
  - On each `tick`, `div_cnt` increments.
  - At `div_cnt`==RUN_DIV-1 with `tick`, a step request is raised and `div_cnt` resets to 0.
  - On a step request:
    - if `bp_en` && `pc_current`==`bp_addr`: go to HALT and do not assert `cpu_ce`;
    - otherwise assert `cpu_ce` next cycle.
  - `run_sw`=0 → IDLE; takes priority over a same-cycle step request (no `cpu_ce`).
  - `btn_rise` is ignored.
  - `div_cnt` is cleared on every exit from RUN.
- HALT:
  - `halted`=1.
  - `btn_rise` → one `cpu_ce` pulse, then RUN (step-off-breakpoint), with no breakpoint check on that step.
  - `run_sw`=0 → IDLE; takes priority over `btn_rise`.
  - `tick` is ignored.
- `step_cnt`:
  - increments by 1 in the same cycle `cpu_ce`=1, modulo 2^CNT_W;
  - `clr_cnt` has priority over a same-cycle increment (result is 0).
- `bp_addr` and `pc_current` are compared combinationally at the request cycle; no latching.

Optional Feature:
- Macro: MIPS_STEP_BURST_EN.
- With the macro defined:
  - Adds input port `burst_len` [7:0] and state BURST=2'd3.
  - In IDLE, `btn_rise` loads `burst_left` = (`burst_len`==0 ? 1 : `burst_len`) and enters BURST.
  - BURST issues one `cpu_ce` per `tick`, decrementing `burst_left` per pulse, and returns to IDLE when it reaches 0.
  - The breakpoint is checked before each burst step; a match goes to HALT without `cpu_ce`.
  - `run_sw`=1 aborts to RUN; `rst` clears `burst_left`.
- Without the macro: no `burst_len` port, no BURST state; the IDLE button behaviour is a single step as above.

Decomposition:
- Package `mips_fpga_pkg`: state encodings (ST_IDLE, ST_RUN, ST_HALT, ST_BURST) and the default RUN_DIV constant.
- Sub-module `edge_rise`: registered rising-edge detector, async active-high reset, outputs a one-cycle pulse. It is reused by other board-level blocks.
- The FSM, divider and counter stay in `mips_step_ctrl`.

Test Plan:
- Reset mid-RUN with `div_cnt`=3 and `step_cnt`=7 → next cycle state=0, `cpu_ce`=0, `step_cnt`=0, `halted`=0.
- IDLE, `btn` held high for 50 cycles → exactly one `cpu_ce` pulse, one cycle after the rise; `step_cnt`=1.
- RUN_DIV=4, `run_sw`=1, `tick` every 10 cycles for 200 cycles → `cpu_ce` pulses on every 4th tick; `step_cnt`=5; no back-to-back `cpu_ce`.
- RUN, `bp_en`=1, `bp_addr`=0x0000_0010, `pc_current` becomes 0x10 → no `cpu_ce` at the next request; state=2; `halted`=1. Then `btn_rise` → one `cpu_ce` and state=1, even though `pc_current` is still 0x10.
- `run_sw` falls in the same cycle as a RUN step request → state=0, no `cpu_ce`. `clr_cnt` in the same cycle as `cpu_ce` → `step_cnt`=0.
- MIPS_STEP_BURST_EN, `burst_len`=3 with `btn_rise` → 3 `cpu_ce` on 3 successive ticks, then state=0. With `burst_len`=0 → exactly 1 `cpu_ce`.

Source files
------------

// File: rtl/mips_fpga_pkg.sv
// Shared definitions for the board-level MIPS control blocks.
// Holds the step-controller state encodings and the default free-run divider.
package mips_fpga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_BURST = 2'd3
  } step_state_t;

  // Number of clk_gen ticks between free-run steps (5 kHz / 5000 = 1 step/s).
  localparam int RUN_DIV_DEFAULT = 5000;

endpackage

// File: rtl/mips_step_ctrl_edge_rise.sv
// edge_rise: registered rising-edge detector used by board-level blocks.
// The input is sampled every cycle; the output pulses for exactly one cycle
// when the input is high and the previous sample was low.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  // Remember last cycle's level so a held input produces only one pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/mips_step_ctrl.sv
// mips_step_ctrl: generates the one-cycle clock enable for the MIPS core.
// Modes: single-step on a button edge (IDLE), free-run at tick/RUN_DIV (RUN),
// and breakpoint stop (HALT). Also counts issued steps for the display.
// Optional burst stepping is compiled in with `define MIPS_STEP_BURST_EN,
// which adds the burst_len port and the BURST state.
module mips_step_ctrl
  import mips_fpga_pkg::*;
#(
  parameter int RUN_DIV = RUN_DIV_DEFAULT,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             btn,
  input  logic             run_sw,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc_current,
  input  logic             clr_cnt,
`ifdef MIPS_STEP_BURST_EN
  input  logic [7:0]       burst_len,
`endif
  output logic             cpu_ce,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] step_cnt
);

  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

  step_state_t      state_q;
  logic [DIV_W-1:0] div_cnt;
  logic             btn_rise;
  logic             bp_hit;
  logic             tick_ok;
  logic             div_last;
`ifdef MIPS_STEP_BURST_EN
  logic [7:0]       burst_left;
`endif

  edge_rise u_btn_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (btn),
    .rise (btn_rise)
  );

  // Breakpoint compare is live: the PC seen in the request cycle decides.
  assign bp_hit   = bp_en && (pc_current == bp_addr);
  // A tick landing while cpu_ce is already high is dropped so that enables
  // can never appear on consecutive cycles.
  assign tick_ok  = tick && !cpu_ce;
  assign div_last = (div_cnt == DIV_W'(RUN_DIV - 1));
  assign state    = state_q;

  // Step-control FSM with registered outputs, free-run divider and step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cpu_ce     <= 1'b0;
      halted     <= 1'b0;
      div_cnt    <= '0;
      step_cnt   <= '0;
`ifdef MIPS_STEP_BURST_EN
      burst_left <= 8'd0;
`endif
    end else begin
      cpu_ce <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          div_cnt <= '0;
          halted  <= 1'b0;
          if (run_sw) begin
            state_q <= ST_RUN;
          end else if (btn_rise) begin
`ifdef MIPS_STEP_BURST_EN
            burst_left <= (burst_len == 8'd0) ? 8'd1 : burst_len;
            state_q    <= ST_BURST;
`else
            cpu_ce <= 1'b1;
`endif
          end
        end

        ST_RUN: begin
          if (!run_sw) begin
            state_q <= ST_IDLE;
            div_cnt <= '0;
          end else if (tick_ok) begin
            if (div_last) begin
              div_cnt <= '0;
              if (bp_hit) begin
                state_q <= ST_HALT;
                halted  <= 1'b1;
              end else begin
                cpu_ce <= 1'b1;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
        end

        ST_HALT: begin
          div_cnt <= '0;
          if (!run_sw) begin
            state_q <= ST_IDLE;
            halted  <= 1'b0;
          end else if (btn_rise) begin
            cpu_ce  <= 1'b1;
            state_q <= ST_RUN;
            halted  <= 1'b0;
          end
        end

`ifdef MIPS_STEP_BURST_EN
        ST_BURST: begin
          div_cnt <= '0;
          if (run_sw) begin
            state_q    <= ST_RUN;
            burst_left <= 8'd0;
          end else if (tick_ok) begin
            if (bp_hit) begin
              state_q    <= ST_HALT;
              halted     <= 1'b1;
              burst_left <= 8'd0;
            end else begin
              cpu_ce     <= 1'b1;
              burst_left <= burst_left - 8'd1;
              if (burst_left <= 8'd1) begin
                state_q <= ST_IDLE;
              end
            end
          end
        end
`endif

        default: begin
          state_q <= ST_IDLE;
          halted  <= 1'b0;
          div_cnt <= '0;
        end
      endcase

      if (clr_cnt) begin
        step_cnt <= '0;
      end else if (cpu_ce) begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_step_ctrl.sv
// Testbench for mips_step_ctrl (RUN_DIV=4). Expected cpu_ce pulse cycles are
// queued when stimulus is driven and matched against observed pulses.
// Define MIPS_STEP_BURST_EN to also exercise burst stepping.
module tb_mips_step_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        btn;
  logic        run_sw;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc_current;
  logic        clr_cnt;
`ifdef MIPS_STEP_BURST_EN
  logic [7:0]  burst_len;
`endif
  logic        cpu_ce;
  logic        halted;
  logic [1:0]  state;
  logic [31:0] step_cnt;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;
  int b2b    = 0;
  logic prev_ce = 1'b0;
  int exp_q[$];
  int obs_q[$];

  mips_step_ctrl #(.RUN_DIV(4), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .btn        (btn),
    .run_sw     (run_sw),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc_current (pc_current),
    .clr_cnt    (clr_cnt),
`ifdef MIPS_STEP_BURST_EN
    .burst_len  (burst_len),
`endif
    .cpu_ce     (cpu_ce),
    .halted     (halted),
    .state      (state),
    .step_cnt   (step_cnt)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge and record any cpu_ce pulse seen there.
  task automatic next_cycle();
    @(negedge clk);
    ncyc++;
    if (cpu_ce === 1'b1) obs_q.push_back(ncyc);
    if (cpu_ce === 1'b1 && prev_ce === 1'b1) b2b++;
    prev_ce = cpu_ce;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 0; btn = 0; run_sw = 0; bp_en = 0;
    bp_addr = 32'h0; pc_current = 32'h0; clr_cnt = 0;
`ifdef MIPS_STEP_BURST_EN
    burst_len = 8'd0;
`endif
    next_cycle(); next_cycle();
    rst = 1'b0;
    next_cycle();
    checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state got %0d want 0", state); end
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("[TB] FAIL reset_ce got %b want 0", cpu_ce); end
    checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted got %b want 0", halted); end
    checks++; if (step_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0d want 0", step_cnt); end
    obs_q.delete();
  endtask

  task automatic test_single_step();
    int e, o;
    next_cycle();
    btn = 1'b1;
    exp_q.push_back(ncyc + 1);
    for (int i = 0; i < 50; i++) next_cycle();
    btn = 1'b0;
    next_cycle();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL single_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o != e) begin errors++; $display("[TB] FAIL single_cycle got %0d want %0d", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (step_cnt !== 32'd1) begin errors++; $display("[TB] FAIL single_cnt got %0d want 1", step_cnt); end
    checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL single_state got %0d want 0", state); end
  endtask

  task automatic test_run();
    int e, o, ticks;
    clr_cnt = 1'b1;
    next_cycle();
    clr_cnt = 1'b0;
    next_cycle();
    checks++; if (step_cnt !== 32'd0) begin errors++; $display("[TB] FAIL clr_cnt got %0d want 0", step_cnt); end
    run_sw = 1'b1;
    b2b = 0;
    ticks = 0;
    for (int i = 0; i < 200; i++) begin
      next_cycle();
      tick = (i % 10 == 9);
      if (tick) begin
        ticks++;
        if (ticks % 4 == 0) exp_q.push_back(ncyc + 1);
      end
    end
    next_cycle(); tick = 1'b0;
    next_cycle();
    checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL run_state got %0d want 1", state); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL run_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o != e) begin errors++; $display("[TB] FAIL run_cycle got %0d want %0d", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (step_cnt !== 32'd5) begin errors++; $display("[TB] FAIL run_cnt got %0d want 5", step_cnt); end
    checks++; if (b2b != 0) begin errors++; $display("[TB] FAIL run_b2b got %0d want 0", b2b); end
  endtask

  task automatic test_breakpoint();
    int e, o;
    bp_en = 1'b1; bp_addr = 32'h0000_0010; pc_current = 32'h0000_0010;
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      tick = (i % 3 == 2);
    end
    next_cycle(); tick = 1'b0;
    next_cycle();
    checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL bp_state got %0d want 2", state); end
    checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL bp_halted got %b want 1", halted); end
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      tick = (i % 3 == 2);
    end
    next_cycle(); tick = 1'b0;
    next_cycle();
    checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL bp_tick_ignored got %0d want 2", state); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL bp_no_ce got %0d want 0", obs_q.size()); end
    obs_q.delete();
    btn = 1'b1;
    exp_q.push_back(ncyc + 1);
    next_cycle();
    btn = 1'b0;
    next_cycle();
    checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL stepoff_state got %0d want 1", state); end
    checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL stepoff_halted got %b want 0", halted); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL stepoff_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o != e) begin errors++; $display("[TB] FAIL stepoff_cycle got %0d want %0d", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    bp_en = 1'b0;
    checks++; if (step_cnt !== 32'd6) begin errors++; $display("[TB] FAIL stepoff_cnt got %0d want 6", step_cnt); end
  endtask

  task automatic test_runsw_priority();
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      tick = (i % 3 == 2);
    end
    next_cycle();
    tick = 1'b1; run_sw = 1'b0;
    next_cycle();
    tick = 1'b0;
    next_cycle();
    next_cycle();
    checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL runsw_state got %0d want 0", state); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL runsw_no_ce got %0d want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_clr_priority();
    next_cycle();
    btn = 1'b1;
    next_cycle();
    checks++; if (cpu_ce !== 1'b1) begin errors++; $display("[TB] FAIL clrpri_ce got %b want 1", cpu_ce); end
    clr_cnt = 1'b1;
    next_cycle();
    clr_cnt = 1'b0; btn = 1'b0;
    checks++; if (step_cnt !== 32'd0) begin errors++; $display("[TB] FAIL clrpri_cnt got %0d want 0", step_cnt); end
    next_cycle();
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int e, o;
    for (int n = 0; n < 7; n++) begin
      next_cycle();
      btn = 1'b1;
      exp_q.push_back(ncyc + 1);
      next_cycle();
      btn = 1'b0;
    end
    next_cycle(); next_cycle();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o != e) begin errors++; $display("[TB] FAIL b2b_cycle got %0d want %0d", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (step_cnt !== 32'd7) begin errors++; $display("[TB] FAIL b2b_cnt got %0d want 7", step_cnt); end
  endtask

  task automatic test_reset_midrun();
    run_sw = 1'b1;
    next_cycle(); next_cycle();
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      tick = (i % 3 == 2);
    end
    next_cycle(); tick = 1'b0;
    #2 rst = 1'b1;
    #1;
    run_sw = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL midreset_state got %0d want 0", state); end
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ce got %b want 0", cpu_ce); end
    checks++; if (step_cnt !== 32'd0) begin errors++; $display("[TB] FAIL midreset_cnt got %0d want 0", step_cnt); end
    checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL midreset_halted got %b want 0", halted); end
    next_cycle();
    rst = 1'b0;
    next_cycle(); next_cycle();
    checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL postreset_state got %0d want 0", state); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL postreset_no_ce got %0d want 0", obs_q.size()); end
    obs_q.delete();
  endtask

`ifdef MIPS_STEP_BURST_EN
  task automatic test_burst();
    int e, o;
    int lens[2] = '{3, 0};
    for (int t = 0; t < 2; t++) begin
      burst_len = 8'(lens[t]);
      next_cycle();
      btn = 1'b1;
      next_cycle();
      btn = 1'b0;
      for (int i = 0; i < 25; i++) begin
        next_cycle();
        tick = (i % 5 == 4);
        if (tick && (i / 5) < ((lens[t] == 0) ? 1 : lens[t])) exp_q.push_back(ncyc + 1);
      end
      next_cycle(); tick = 1'b0;
      next_cycle();
      checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL burst_state got %0d want 0", state); end
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL burst_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks++; if (o != e) begin errors++; $display("[TB] FAIL burst_cycle got %0d want %0d", o, e); end
      end
      exp_q.delete(); obs_q.delete();
    end
  endtask
`endif

  // Scenario sequence; each task checks its own results.
  initial begin
    test_reset();
    test_single_step();
    test_run();
    test_breakpoint();
    test_runsw_priority();
    test_clr_priority();
    test_back_to_back();
    test_reset_midrun();
`ifdef MIPS_STEP_BURST_EN
    test_burst();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
